sensor_filter: RTL and testbench

//  Conditions the three raw reflective line sensors (left, middle, right) into clean

---
 rtl/sensor_filter.sv | 88 ++++++++
 tb/tb_sensor_filter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sensor_filter.sv
// Line-sensor conditioner: per-channel 2-flop synchroniser, prescaled sampling and a
// saturating up/down integrator with hysteresis; strobes whenever any filtered level changes.
module sensor_filter #(
  parameter int unsigned PRESCALE = 500,
  parameter int unsigned INT_W    = 4,
  parameter int unsigned INT_MAX  = 15,
  parameter int unsigned HI_TH    = 12,
  parameter int unsigned LO_TH    = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic sensorLeftRaw,
  input  logic sensorMiddleRaw,
  input  logic sensorRightRaw,
  output logic sensorLeftFiltered,
  output logic sensorMiddleFiltered,
  output logic sensorRightFiltered,
  output logic sensorsChanged
);

  localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CntW-1:0]  CntLast = CntW'(PRESCALE - 1);
  localparam logic [INT_W-1:0] IntMax  = INT_W'(INT_MAX);
  localparam logic [INT_W-1:0] HiTh    = INT_W'(HI_TH);
  localparam logic [INT_W-1:0] LoTh    = INT_W'(LO_TH);

  // Channel order in all vectors: [2]=left, [1]=middle, [0]=right.
  logic [2:0]       raw;
  logic [2:0]       sync1_q, sync2_q;
  logic [2:0]       filt_d, filt_q;
  logic [CntW-1:0]  cnt_q;
  logic             tick;
  logic             changed_q;
  logic [INT_W-1:0] int_q [3];
  logic [INT_W-1:0] int_d [3];

  assign raw  = {sensorLeftRaw, sensorMiddleRaw, sensorRightRaw};
  assign tick = (cnt_q == CntLast);

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      int_d[i]  = int_q[i];
      filt_d[i] = filt_q[i];
      if (tick) begin
        if (sync2_q[i] && (int_q[i] < IntMax)) begin
          int_d[i] = int_q[i] + INT_W'(1);
        end else if (!sync2_q[i] && (int_q[i] != '0)) begin
          int_d[i] = int_q[i] - INT_W'(1);
        end
        // Between the thresholds the previous level is held.
        if (int_d[i] >= HiTh) begin
          filt_d[i] = 1'b1;
        end else if (int_d[i] <= LoTh) begin
          filt_d[i] = 1'b0;
        end
      end
    end
  end

  // All-ones after reset makes the downstream controller stop the motors until data settles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= 3'b111;
      sync2_q   <= 3'b111;
      cnt_q     <= '0;
      filt_q    <= 3'b111;
      changed_q <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        int_q[i] <= IntMax;
      end
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      cnt_q     <= tick ? '0 : cnt_q + 1'b1;
      filt_q    <= filt_d;
      changed_q <= (filt_d != filt_q);
      for (int i = 0; i < 3; i++) begin
        int_q[i] <= int_d[i];
      end
    end
  end

  assign sensorLeftFiltered   = filt_q[2];
  assign sensorMiddleFiltered = filt_q[1];
  assign sensorRightFiltered  = filt_q[0];
  assign sensorsChanged       = changed_q;

endmodule

// File: tb/tb_sensor_filter.sv
// Directed bench for sensor_filter: expected strobe events (edge number and filtered levels)
// are queued as stimulus is applied and checked by a monitor when sensorsChanged fires.
module tb_sensor_filter;

  localparam int PRESCALE = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       l_raw = 1'b0, m_raw = 1'b0, r_raw = 1'b0;
  logic       l_f, m_f, r_f, chg;
  logic [2:0] filt;

  assign filt = {l_f, m_f, r_f};

  sensor_filter #(
    .PRESCALE(PRESCALE),
    .INT_W   (4),
    .INT_MAX (15),
    .HI_TH   (12),
    .LO_TH   (3)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .sensorLeftRaw       (l_raw),
    .sensorMiddleRaw     (m_raw),
    .sensorRightRaw      (r_raw),
    .sensorLeftFiltered  (l_f),
    .sensorMiddleFiltered(m_f),
    .sensorRightFiltered (r_f),
    .sensorsChanged      (chg)
  );

  always #5 clk = ~clk;

  // Posedge counter; at a negedge it holds the number of the edge just passed.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int         edge_n;
    logic [2:0] filt;
  } ev_t;

  ev_t  sb[$];
  ev_t  mon_ev;
  int   n_chk = 0, n_pass = 0, n_fail = 0;
  int   rel = 0;   // edge count at the negedge where reset was released
  int   b;
  logic [2:0] prev_filt = 3'b111;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Edge of the n-th sample tick that sees a raw change applied at the negedge after edge bb
  // (two synchroniser edges, then ticks every PRESCALE edges counted from reset release).
  function automatic int tick_n(input int bb, input int n);
    int e = bb + 3;
    while (!((e > rel) && (((e - rel) % PRESCALE) == 0))) e++;
    return e + PRESCALE * (n - 1);
  endfunction

  task automatic wait_edge(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  task automatic expect_ev(input int e, input logic [2:0] f);
    sb.push_back(ev_t'{e, f});
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      check("sb_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  // Every strobe must match the next queued event; every level change must carry a strobe.
  always @(negedge clk) begin
    if (reset) begin
      prev_filt = 3'b111;
    end else begin
      if (chg) begin
        check("strobe_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          mon_ev = sb.pop_front();
          check("strobe_edge", cyc, mon_ev.edge_n);
          check("strobe_filt", filt, mon_ev.filt);
        end
      end else if (filt !== prev_filt) begin
        check("strobe_on_change", chg, 1);
      end
      prev_filt = filt;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1. Reset with raw all 0: all three fall together 12 ticks after release.
    repeat (3) @(negedge clk);
    check("rst_filt", filt, 3'b111);
    check("rst_strobe", chg, 0);
    reset = 1'b0;
    rel = cyc;
    expect_ev(rel + 48, 3'b000);
    wait_edge(rel + 47);
    check("t1_before_fall", filt, 3'b111);
    wait_drain(80);
    wait_edge(rel + 60);
    check("t1_settled", filt, 3'b000);

    // 2. Left rises from int=0 on the 12th tick; held until int saturates at 15.
    b = cyc;
    l_raw = 1'b1;
    expect_ev(tick_n(b, 12), 3'b100);
    wait_edge(tick_n(b, 11));
    check("t2_before_rise", filt, 3'b000);
    wait_drain(80);
    wait_edge(tick_n(b, 15));
    check("t2_high", filt, 3'b100);

    // 4. Hysteresis: 11 zero ticks keep it high, the 12th drops it, 8 one ticks keep it low.
    b = cyc;
    l_raw = 1'b0;
    wait_edge(tick_n(b, 11));
    check("t4_hold_high", filt, 3'b100);
    expect_ev(tick_n(b, 12), 3'b000);
    wait_edge(tick_n(b, 12));
    b = cyc;
    l_raw = 1'b1;
    wait_edge(tick_n(b, 8));
    l_raw = 1'b0;
    check("t4_hold_low", filt, 3'b000);
    check("t4_fall_seen", sb.size(), 0);
    b = cyc;
    wait_edge(tick_n(b, 12));

    // 3. Glitch: 5 high ticks from int=0 never reach the upper threshold.
    b = cyc;
    l_raw = 1'b1;
    wait_edge(tick_n(b, 5));
    l_raw = 1'b0;
    b = cyc;
    wait_edge(tick_n(b, 8));
    check("t3_glitch", filt, 3'b000);

    // 5. Middle to 15, then middle falls and right rises on the same tick: one strobe.
    b = cyc;
    m_raw = 1'b1;
    expect_ev(tick_n(b, 12), 3'b010);
    wait_edge(tick_n(b, 15));
    check("t5_mid_high", filt, 3'b010);
    b = cyc;
    m_raw = 1'b0;
    r_raw = 1'b1;
    expect_ev(tick_n(b, 12), 3'b001);
    wait_edge(tick_n(b, 11));
    check("t5_before_swap", filt, 3'b010);
    wait_drain(80);
    check("t5_swapped", filt, 3'b001);

    // 6. Left to int=8, then asynchronous reset between clock edges.
    b = cyc;
    l_raw = 1'b1;
    wait_edge(tick_n(b, 8));
    check("t6_partial", filt, 3'b001);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("t6_async_filt", filt, 3'b111);
    check("t6_async_strobe", chg, 0);
    l_raw = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rel = cyc;
    // Left restarts from 15, not 8: it falls with middle on the 12th tick after release.
    expect_ev(rel + 48, 3'b001);
    wait_edge(rel + 47);
    check("t6_before_fall", filt, 3'b111);
    wait_drain(80);
    wait_edge(cyc + 8);
    check("t6_final", filt, 3'b001);
    check("sb_empty", sb.size(), 0);

    if (n_fail != 0) $display("%0d comparisons did not match", n_fail);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
